// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline.
// Turns hazard and decode status into per-stage enables and flushes:
// load-use stalls, taken-redirect flushes, data-memory freezes and the
// halt drain. It also keeps saturating performance counters.
// All stage controls are combinational from the current state and inputs.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_halt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             halted,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] cycles_q, stalls_q, flushes_q;
    logic             cyc_inc, stall_inc, flush_inc;
    logic             mstall, lu;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        if (inc && (v != '1)) return v + CNT_W'(1);
        return v;
    endfunction

    assign mstall = mem_access & ~dmem_ready;
    assign lu     = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

    // Next-state, stage controls and counter increments; reset forces controls low.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        halted      = 1'b0;
        cyc_inc     = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            RUN: begin
                cyc_inc   = 1'b1;
                stall_inc = mstall | lu;
                if (mstall) begin
                    // freeze: everything held, hazards re-evaluated next cycle
                end else if (ex_taken) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (lu) begin
                    {id_ex_en, ex_mem_en, mem_wb_en} = '1;
                    id_ex_flush = 1'b1;
                end else if (id_halt) begin
                    {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = DRAIN;
                    drain_d     = DRAIN_INIT;
                end else begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
                end
            end
            DRAIN: begin
                cyc_inc     = 1'b1;
                stall_inc   = mstall;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = {4{~mstall}};
                if (!mstall) begin
                    drain_d = drain_q - 4'd1;
                    if (drain_q == 4'd1) state_d = HALTED;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (!reset) begin
            {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en} = '0;
            halted = 1'b0;
        end
    end

    // State, drain countdown and saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            drain_q   <= 4'd0;
            cycles_q  <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            cycles_q  <= sat_inc(cycles_q, cyc_inc);
            stalls_q  <= sat_inc(stalls_q, stall_inc);
            flushes_q <= sat_inc(flushes_q, flush_inc);
        end
    end

    assign perf_cycles  = cycles_q;
    assign perf_stalls  = stalls_q;
    assign perf_flushes = flushes_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expected
// stage controls and counter values; a monitor on the falling edge pops
// and compares. A second instance with 3-bit counters exercises saturation.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_halt = 1'b0;
    logic       ex_mem_read = 1'b0, ex_taken = 1'b0, mem_access = 1'b0, dmem_ready = 1'b1;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted;
    logic [31:0] perf_cycles, perf_stalls, perf_flushes;
    logic        pc_en2, if_id_en2, if_id_flush2, id_ex_en2, id_ex_flush2, ex_mem_en2, mem_wb_en2, halted2;
    logic [2:0]  perf_cycles2, perf_stalls2, perf_flushes2;

    always #5 clk = ~clk;

    pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_halt(id_halt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_taken(ex_taken),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .halted(halted), .perf_cycles(perf_cycles),
        .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
    );

    pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_halt(id_halt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_taken(ex_taken),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en2), .if_id_en(if_id_en2), .if_id_flush(if_id_flush2),
        .id_ex_en(id_ex_en2), .id_ex_flush(id_ex_flush2), .ex_mem_en(ex_mem_en2),
        .mem_wb_en(mem_wb_en2), .halted(halted2), .perf_cycles(perf_cycles2),
        .perf_stalls(perf_stalls2), .perf_flushes(perf_flushes2)
    );

    // Output bit order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    localparam logic [6:0] O_ZERO  = 7'b0000000;
    localparam logic [6:0] O_NORM  = 7'b1101011;
    localparam logic [6:0] O_REDIR = 7'b1111111;
    localparam logic [6:0] O_LU    = 7'b0001111;
    localparam logic [6:0] O_DRAIN = 7'b0011111;
    localparam logic [6:0] O_DWAIT = 7'b0010100;
    localparam logic [6:0] M_ALL   = 7'b1111111;
    localparam logic [6:0] M_NOIF  = 7'b1011111;

    typedef struct {
        logic [6:0] outs;
        logic [6:0] mask;
        logic       hlt;
        int         cyc;
        int         stl;
        int         fls;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [2:0] sat3(input int v);
        return (v > 7) ? 3'd7 : v[2:0];
    endfunction

    task automatic step(input logic rst_v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic hlt_i, input logic [4:0] rd,
                        input logic mr, input logic tk, input logic ma, input logic rdy,
                        input logic [6:0] eo, input logic [6:0] em, input logic eh,
                        input int ec, input int es, input int ef, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_halt = hlt_i; ex_rd = rd; ex_mem_read = mr; ex_taken = tk;
        mem_access = ma; dmem_ready = rdy;
        e.outs = eo; e.mask = em; e.hlt = eh; e.cyc = ec; e.stl = es; e.fls = ef; e.name = nm;
        sbq.push_back(e);
    endtask

    // Monitor: one expected entry per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            logic [6:0] a1, a2;
            logic bad;
            e = sbq.pop_front();
            bad = 1'b0;
            a1 = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
            a2 = {pc_en2, if_id_en2, if_id_flush2, id_ex_en2, id_ex_flush2, ex_mem_en2, mem_wb_en2};
            vectors++;
            if (((a1 ^ e.outs) & e.mask) != 0 || halted !== e.hlt) begin
                $display("FAIL %s ctrl: got %b halted=%b, want %b (mask %b) halted=%b", e.name, a1, halted, e.outs, e.mask, e.hlt);
                bad = 1'b1;
            end
            if (((a2 ^ e.outs) & e.mask) != 0 || halted2 !== e.hlt) begin
                $display("FAIL %s ctrl_sat: got %b halted=%b, want %b (mask %b) halted=%b", e.name, a2, halted2, e.outs, e.mask, e.hlt);
                bad = 1'b1;
            end
            if (perf_cycles !== 32'(e.cyc) || perf_stalls !== 32'(e.stl) || perf_flushes !== 32'(e.fls)) begin
                $display("FAIL %s counters: got c=%0d s=%0d f=%0d, want c=%0d s=%0d f=%0d", e.name,
                         perf_cycles, perf_stalls, perf_flushes, e.cyc, e.stl, e.fls);
                bad = 1'b1;
            end
            if (perf_cycles2 !== sat3(e.cyc) || perf_stalls2 !== sat3(e.stl) || perf_flushes2 !== sat3(e.fls)) begin
                $display("FAIL %s sat_counters: got c=%0d s=%0d f=%0d, want c=%0d s=%0d f=%0d", e.name,
                         perf_cycles2, perf_stalls2, perf_flushes2, sat3(e.cyc), sat3(e.stl), sat3(e.fls));
                bad = 1'b1;
            end
            if (bad) miscompares++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        //    rst rs1 rs2 u1 u2 hlt rd mr tk ma rdy  outs     mask    h  cyc stl fls
        step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, O_ZERO,  M_ALL,  0, 0,  0, 0, "reset");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_NORM,  M_ALL,  0, 0,  0, 0, "run_idle");
        step(1, 5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 0, 0, 1, O_LU,    M_ALL,  0, 1,  0, 0, "lu_rs1");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_NORM,  M_ALL,  0, 2,  1, 0, "after_lu");
        step(1, 5'd0, 5'd0, 1, 0, 0, 5'd0, 1, 0, 0, 1, O_NORM,  M_ALL,  0, 3,  1, 0, "lu_x0");
        step(1, 5'd0, 5'd7, 0, 1, 0, 5'd7, 1, 0, 0, 1, O_LU,    M_ALL,  0, 4,  1, 0, "lu_rs2");
        step(1, 5'd0, 5'd7, 0, 0, 0, 5'd7, 1, 0, 0, 1, O_NORM,  M_ALL,  0, 5,  2, 0, "lu_unused");
        step(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 1, 0, 1, O_REDIR, M_ALL,  0, 6,  2, 0, "branch_halt");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_NORM,  M_ALL,  0, 7,  2, 1, "still_run");
        for (int i = 0; i < 4; i++)
            step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0, O_ZERO, M_ALL, 0, 8 + i, 2 + i, 1, "mfreeze");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1, O_REDIR, M_ALL,  0, 12, 6, 1, "mready_flush");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_NORM,  M_ALL,  0, 13, 6, 2, "post_freeze");
        step(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 1, O_DRAIN, M_NOIF, 0, 14, 6, 2, "halt_t");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, O_DRAIN, M_NOIF, 0, 15, 6, 2, "drain1_tk");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_DRAIN, M_NOIF, 0, 16, 6, 2, "drain2");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_DRAIN, M_NOIF, 0, 17, 6, 2, "drain3");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_ZERO,  M_ALL,  1, 18, 6, 2, "halted");
        step(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 1, 0, 1, O_ZERO,  M_ALL,  1, 18, 6, 2, "halted_hold");
        step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_ZERO,  M_ALL,  0, 0,  0, 0, "reset_halted");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_NORM,  M_ALL,  0, 0,  0, 0, "rerun");
        step(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 1, O_DRAIN, M_NOIF, 0, 1,  0, 0, "halt2_t");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_DRAIN, M_NOIF, 0, 2,  0, 0, "d2_1");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, O_DWAIT, M_NOIF, 0, 3,  0, 0, "d2_wait");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_DRAIN, M_NOIF, 0, 4,  1, 0, "d2_2");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_DRAIN, M_NOIF, 0, 5,  1, 0, "d2_3");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_ZERO,  M_ALL,  1, 6,  1, 0, "d2_halted");
        step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_ZERO,  M_ALL,  0, 0,  0, 0, "reset2");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_NORM,  M_ALL,  0, 0,  0, 0, "rerun2");
        step(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 1, O_DRAIN, M_NOIF, 0, 1,  0, 0, "halt3_t");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_DRAIN, M_NOIF, 0, 2,  0, 0, "d3_1");
        step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_ZERO,  M_ALL,  0, 0,  0, 0, "reset_middrain");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_NORM,  M_ALL,  0, 0,  0, 0, "run_after_rst");
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, O_NORM,  M_ALL,  0, 1,  0, 0, "run_after_rst2");
        @(posedge clk);
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            $display("FAIL drain_queue: got %0d pending, want 0", sbq.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
